gb_host_arb: RTL and testbench

- Two-requester arbiter sharing one ghostbus host port between two independent host bridges (e.g. UART bridge on port A, packet bridge on port B).
- Serialises single-word read/write transactions from both requesters onto the ghostbus.
- Inserts the fixed read latency of the decoded register/RAM tree and routes returned read data to the requester that issued the read.
- Sits at the top level, directly above the auto-decoded ghostbus tree.

---
 rtl/gb_host_arb_pkg.sv | 24 ++
 rtl/gb_host_arb_if.sv | 41 ++++
 rtl/gb_host_arb_rr_arb2.sv | 30 +++
 rtl/gb_host_arb.sv | 123 ++++++++++++
 tb/tb_gb_host_arb.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_host_arb_pkg.sv
// Shared types for the ghostbus host arbiter: FSM states, grant encoding
// and the read-latency counter width.
package gb_host_arb_pkg;

  localparam int CNT_W      = 4;
  localparam int RD_LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  function automatic gnt_t gnt_other(input gnt_t g);
    return (g == GNT_A) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/gb_host_arb_if.sv
// Requester A/B handshake signals plus the ghostbus host port.
// slave = arbiter view, master = requesters and the decoded bus tree.
interface gb_host_arb_if #(
  parameter int AW = 24,
  parameter int DW = 32
) ();
  logic          a_req, a_we, a_re;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack, a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req, b_we, b_re;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack, b_rvalid;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_we, gb_re;
  logic [DW-1:0] gb_rdata;

  modport slave (
    input  a_req, a_we, a_re, a_addr, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_we, b_re, b_addr, b_wdata,
    output b_ack, b_rvalid, b_rdata,
    output gb_addr, gb_wdata, gb_we, gb_re,
    input  gb_rdata
  );

  modport master (
    output a_req, a_we, a_re, a_addr, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_we, b_re, b_addr, b_wdata,
    input  b_ack, b_rvalid, b_rdata,
    input  gb_addr, gb_wdata, gb_we, gb_re,
    output gb_rdata
  );
endinterface

// File: rtl/gb_host_arb_rr_arb2.sv
// Two-way round-robin picker; owns the priority pointer.
// Latency: combinational pick, pointer moves on the advance edge.
// Backpressure: none; the pointer only moves when both sides contend.
module rr_arb2
  import gb_host_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output gnt_t       gnt,
  output logic       valid
);

  gnt_t ptr;

  always_comb begin
    valid = |req;
    if (req == 2'b11) gnt = ptr;
    else if (req[1])  gnt = GNT_B;
    else              gnt = GNT_A;
  end

  // A lone requester does not consume its turn.
  always_ff @(posedge clk) begin
    if (rst)                         ptr <= GNT_A;
    else if (advance && req == 2'b11) ptr <= gnt_other(gnt);
  end

endmodule

// File: rtl/gb_host_arb.sv
// Serialises single-word ghostbus transactions from two host bridges.
// Latency: ack one cycle after grant; rvalid RD_LAT+1 cycles after gb_re.
// Backpressure: requester holds req until ack; one transaction in flight.
module gb_host_arb
  import gb_host_arb_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  gb_host_arb_if.slave bus
);

  state_t           state;
  gnt_t             gnt_q, pick;
  logic             pick_vld;
  logic             op_re;
  logic [CNT_W-1:0] cnt;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q, re_q;
  logic          a_ack_q, b_ack_q, a_rvalid_q, b_rvalid_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  logic          sel_we, sel_re;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.b_req, bus.a_req}),
    .advance (state == ST_IDLE),
    .gnt     (pick),
    .valid   (pick_vld)
  );

  assign sel_we    = (pick == GNT_B) ? bus.b_we    : bus.a_we;
  assign sel_re    = (pick == GNT_B) ? bus.b_re    : bus.a_re;
  assign sel_addr  = (pick == GNT_B) ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = (pick == GNT_B) ? bus.b_wdata : bus.a_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt_q      <= GNT_A;
      op_re      <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      case (state)
        // Strobes and ack are loaded here so they are live for exactly the ISSUE cycle.
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q   <= pick;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            re_q    <= sel_re & ~sel_we;
            op_re   <= sel_re & ~sel_we;
            a_ack_q <= (pick == GNT_A);
            b_ack_q <= (pick == GNT_B);
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (op_re) begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            if (gnt_q == GNT_A) begin
              a_rdata_q  <= bus.gb_rdata;
              a_rvalid_q <= 1'b1;
            end else begin
              b_rdata_q  <= bus.gb_rdata;
              b_rvalid_q <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gb_addr  = addr_q;
  assign bus.gb_wdata = wdata_q;
  assign bus.gb_we    = we_q;
  assign bus.gb_re    = re_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_gb_host_arb.sv
// Bench for gb_host_arb: three instances (RD_LAT 1, 2, 15) share one set of
// requester stimulus; the RD_LAT=2 instance is the main one and is logged.
module tb_gb_host_arb;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int LAT = 2;
  localparam logic [DW-1:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0, a_re = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0, b_re = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  gb_host_arb_if #(.AW(AW), .DW(DW)) bus1 ();
  gb_host_arb_if #(.AW(AW), .DW(DW)) bus2 ();
  gb_host_arb_if #(.AW(AW), .DW(DW)) bus15 ();

  assign bus1.a_req = a_req;   assign bus1.a_we = a_we;   assign bus1.a_re = a_re;
  assign bus1.a_addr = a_addr; assign bus1.a_wdata = a_wdata;
  assign bus1.b_req = b_req;   assign bus1.b_we = b_we;   assign bus1.b_re = b_re;
  assign bus1.b_addr = b_addr; assign bus1.b_wdata = b_wdata;
  assign bus2.a_req = a_req;   assign bus2.a_we = a_we;   assign bus2.a_re = a_re;
  assign bus2.a_addr = a_addr; assign bus2.a_wdata = a_wdata;
  assign bus2.b_req = b_req;   assign bus2.b_we = b_we;   assign bus2.b_re = b_re;
  assign bus2.b_addr = b_addr; assign bus2.b_wdata = b_wdata;
  assign bus15.a_req = a_req;   assign bus15.a_we = a_we;   assign bus15.a_re = a_re;
  assign bus15.a_addr = a_addr; assign bus15.a_wdata = a_wdata;
  assign bus15.b_req = b_req;   assign bus15.b_we = b_we;   assign bus15.b_re = b_re;
  assign bus15.b_addr = b_addr; assign bus15.b_wdata = b_wdata;

  gb_host_arb #(.AW(AW), .DW(DW), .RD_LAT(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  gb_host_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  gb_host_arb #(.AW(AW), .DW(DW), .RD_LAT(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

  // Register tree model: data appears exactly RD_LAT cycles after gb_re, garbage otherwise.
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    if (a == 24'h000010) return 32'h42;
    return {8'hC3, a} ^ 32'h5A5A_5A5A;
  endfunction

  logic          pv1[16], pv2[16], pv15[16];
  logic [DW-1:0] pd1[16], pd2[16], pd15[16];

  always @(posedge clk) begin
    for (int j = 15; j > 0; j--) begin
      pv1[j] <= pv1[j-1];   pd1[j] <= pd1[j-1];
      pv2[j] <= pv2[j-1];   pd2[j] <= pd2[j-1];
      pv15[j] <= pv15[j-1]; pd15[j] <= pd15[j-1];
    end
    pv1[0] <= bus1.gb_re;   pd1[0] <= rd_fn(bus1.gb_addr);
    pv2[0] <= bus2.gb_re;   pd2[0] <= rd_fn(bus2.gb_addr);
    pv15[0] <= bus15.gb_re; pd15[0] <= rd_fn(bus15.gb_addr);
  end

  assign bus1.gb_rdata  = pv1[0]   ? pd1[0]   : BAD;
  assign bus2.gb_rdata  = pv2[1]   ? pd2[1]   : BAD;
  assign bus15.gb_rdata = pv15[14] ? pd15[14] : BAD;

  typedef struct {
    int            cyc;
    logic          we;
    logic          re;
    logic          aa;
    logic          ba;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } ev_t;

  typedef struct {
    int            cyc;
    logic          side;
    logic [DW-1:0] d;
  } rv_t;

  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } txn_t;

  ev_t  ev_q[$];
  rv_t  rv_q[$];
  txn_t tl[2][4];

  always @(negedge clk) begin
    if (bus2.gb_we || bus2.gb_re || bus2.a_ack || bus2.b_ack)
      ev_q.push_back('{cyc, bus2.gb_we, bus2.gb_re, bus2.a_ack, bus2.b_ack, bus2.gb_addr, bus2.gb_wdata});
    if (bus2.a_rvalid) rv_q.push_back('{cyc, 1'b0, bus2.a_rdata});
    if (bus2.b_rvalid) rv_q.push_back('{cyc, 1'b1, bus2.b_rdata});
    cyc <= cyc + 1;
  end

  task automatic set_req(input bit side, input bit r, input bit we, input bit re,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    if (!side) begin
      a_req = r; a_we = we; a_re = re; a_addr = ad; a_wdata = wd;
    end else begin
      b_req = r; b_we = we; b_re = re; b_addr = ad; b_wdata = wd;
    end
  endtask

  task automatic wait_ack(input bit side, input int budget, output int ac);
    ac = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((side ? bus2.b_ack : bus2.a_ack) === 1'b1) begin
        ac = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ev_q.delete();
    rv_q.delete();
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flags = {bus2.a_ack, bus2.b_ack, bus2.a_rvalid, bus2.b_rvalid, bus2.gb_we, bus2.gb_re};
    n_checks++;
    if (flags !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", flags); end
    n_checks++;
    if ({bus2.a_rdata, bus2.b_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus2.a_rdata, bus2.b_rdata);
    end
    n_checks++;
    if ({bus2.gb_addr, bus2.gb_wdata} !== 56'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h expected 0/0", bus2.gb_addr, bus2.gb_wdata);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL idle_no_activity: got %0d events expected 0", ev_q.size()); end
  endtask

  task automatic test_write();
    int t, ac;
    do_reset();
    @(posedge clk); #1 set_req(1'b0, 1'b1, 1'b1, 1'b0, 24'h000040, 32'h5);
    @(negedge clk); t = cyc;
    wait_ack(1'b0, 10, ac);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 1'b0, 24'h000040, 32'h5);
    repeat (5) @(negedge clk);
    n_checks++;
    if (ac !== t + 1) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d expected %0d", ac, t + 1); end
    n_checks++;
    if (ev_q.size() != 1) begin
      n_fail++; $display("FAIL wr_event_count: got %0d expected 1", ev_q.size());
    end else begin
      n_checks++;
      if ({ev_q[0].we, ev_q[0].re, ev_q[0].aa, ev_q[0].ba} !== 4'b1010) begin
        n_fail++; $display("FAIL wr_strobes: got we/re/aa/ba=%b expected 1010",
                           {ev_q[0].we, ev_q[0].re, ev_q[0].aa, ev_q[0].ba});
      end
      n_checks++;
      if (ev_q[0].addr !== 24'h000040 || ev_q[0].wd !== 32'h5 || ev_q[0].cyc != t + 1) begin
        n_fail++; $display("FAIL wr_bus: got addr=%h wd=%h cyc=%0d expected 000040 00000005 %0d",
                           ev_q[0].addr, ev_q[0].wd, ev_q[0].cyc, t + 1);
      end
    end
    n_checks++;
    if (bus2.gb_addr !== 24'h000040 || bus2.gb_wdata !== 32'h5) begin
      n_fail++; $display("FAIL wr_bus_hold: got %h/%h expected 000040/00000005", bus2.gb_addr, bus2.gb_wdata);
    end
    n_checks++;
    if (rv_q.size() != 0) begin n_fail++; $display("FAIL wr_no_rvalid: got %0d expected 0", rv_q.size()); end
  endtask

  task automatic test_read();
    int ac;
    do_reset();
    @(posedge clk); #1 set_req(1'b1, 1'b1, 1'b0, 1'b1, 24'h000010, 32'h0);
    wait_ack(1'b1, 10, ac);
    @(posedge clk); #1 set_req(1'b1, 1'b0, 1'b0, 1'b0, 24'h000010, 32'h0);
    repeat (8) @(negedge clk);
    n_checks++;
    if (ev_q.size() != 1 || ev_q[0].re !== 1'b1 || ev_q[0].we !== 1'b0 || ev_q[0].ba !== 1'b1) begin
      n_fail++; $display("FAIL rd_issue: got %0d events expected one B read strobe", ev_q.size());
    end
    n_checks++;
    if (rv_q.size() != 1) begin
      n_fail++; $display("FAIL rd_rvalid_count: got %0d expected 1", rv_q.size());
    end else begin
      n_checks++;
      if (rv_q[0].side !== 1'b1 || rv_q[0].d !== 32'h42 || rv_q[0].cyc != ac + LAT + 1) begin
        n_fail++; $display("FAIL rd_response: got side=%0d d=%h cyc=%0d expected 1 00000042 %0d",
                           rv_q[0].side, rv_q[0].d, rv_q[0].cyc, ac + LAT + 1);
      end
    end
    n_checks++;
    if (bus2.b_rdata !== 32'h42 || bus2.a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rd_hold: got b=%h a=%h expected 00000042/00000000", bus2.b_rdata, bus2.a_rdata);
    end
  endtask

  task automatic run_side(input bit side);
    int ac;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_req(side, 1'b1, tl[side][i].we, tl[side][i].re, tl[side][i].addr, tl[side][i].wd);
      wait_ack(side, 40, ac);
      n_checks++;
      if (ac < 0) begin n_fail++; $display("FAIL alt_ack_timeout side=%0d txn=%0d: got none expected ack", side, i); end
    end
    @(posedge clk); #1 set_req(side, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_alternate();
    rv_t exp_rv[$];
    for (int r = 0; r < 3; r++) begin
      int op;
      do_reset();
      exp_rv.delete();
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < 4; i++) begin
          op = int'($urandom_range(0, 3));
          tl[s][i].we   = (op == 1 || op == 3);
          tl[s][i].re   = (op == 2 || op == 3);
          tl[s][i].addr = AW'($urandom);
          tl[s][i].wd   = $urandom;
        end
      end
      fork
        run_side(1'b0);
        run_side(1'b1);
      join
      repeat (10) @(negedge clk);
      n_checks++;
      if (ev_q.size() != 8) begin n_fail++; $display("FAIL alt_event_count: got %0d expected 8", ev_q.size()); end
      for (int k = 0; k < 8; k++) begin
        if (k < ev_q.size()) begin
          txn_t t, p;
          logic side;
          logic [3:0] exp_f;
          int exp_gap;
          side  = 1'(k % 2);
          t     = tl[k % 2][k / 2];
          exp_f = {t.we, t.re & ~t.we, side == 1'b0, side == 1'b1};
          n_checks++;
          if ({ev_q[k].we, ev_q[k].re, ev_q[k].aa, ev_q[k].ba} !== exp_f) begin
            n_fail++; $display("FAIL alt_order k=%0d: got we/re/aa/ba=%b expected %b", k,
                               {ev_q[k].we, ev_q[k].re, ev_q[k].aa, ev_q[k].ba}, exp_f);
          end
          n_checks++;
          if (ev_q[k].addr !== t.addr || ev_q[k].wd !== t.wd) begin
            n_fail++; $display("FAIL alt_fields k=%0d: got %h/%h expected %h/%h", k,
                               ev_q[k].addr, ev_q[k].wd, t.addr, t.wd);
          end
          if (k > 0) begin
            p = tl[(k - 1) % 2][(k - 1) / 2];
            exp_gap = (p.re && !p.we) ? LAT + 3 : 2;
            n_checks++;
            if (ev_q[k].cyc - ev_q[k-1].cyc != exp_gap) begin
              n_fail++; $display("FAIL alt_gap k=%0d: got %0d expected %0d", k,
                                 ev_q[k].cyc - ev_q[k-1].cyc, exp_gap);
            end
          end
          if (t.re && !t.we) exp_rv.push_back('{ev_q[k].cyc + LAT + 1, side, rd_fn(t.addr)});
        end
      end
      n_checks++;
      if (rv_q.size() != exp_rv.size()) begin
        n_fail++; $display("FAIL alt_rvalid_count: got %0d expected %0d", rv_q.size(), exp_rv.size());
      end else begin
        foreach (exp_rv[i]) begin
          n_checks++;
          if (rv_q[i].cyc != exp_rv[i].cyc || rv_q[i].side !== exp_rv[i].side || rv_q[i].d !== exp_rv[i].d) begin
            n_fail++; $display("FAIL alt_resp i=%0d: got cyc=%0d side=%0d d=%h expected cyc=%0d side=%0d d=%h", i,
                               rv_q[i].cyc, rv_q[i].side, rv_q[i].d, exp_rv[i].cyc, exp_rv[i].side, exp_rv[i].d);
          end
        end
      end
    end
  endtask

  task automatic test_single_op(input bit we, input bit re, input logic [AW-1:0] ad, input logic [3:0] exp_f);
    int ac;
    do_reset();
    @(posedge clk); #1 set_req(1'b0, 1'b1, we, re, ad, 32'h1234);
    wait_ack(1'b0, 10, ac);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ev_q.size() != 1) begin
      n_fail++; $display("FAIL op%b%b_count: got %0d expected 1", we, re, ev_q.size());
    end else begin
      n_checks++;
      if ({ev_q[0].we, ev_q[0].re, ev_q[0].aa, ev_q[0].ba} !== exp_f) begin
        n_fail++; $display("FAIL op%b%b_strobes: got %b expected %b", we, re,
                           {ev_q[0].we, ev_q[0].re, ev_q[0].aa, ev_q[0].ba}, exp_f);
      end
    end
    n_checks++;
    if (rv_q.size() != 0) begin n_fail++; $display("FAIL op%b%b_no_rvalid: got %0d expected 0", we, re, rv_q.size()); end
  endtask

  task automatic test_reset_mid();
    int ac, ac_a, ac_b;
    logic [5:0] flags;
    do_reset();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 24'h000030, 32'h0);
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 24'h000050, 32'h77);
    wait_ack(1'b0, 10, ac);
    n_checks++;
    if (ac < 0) begin n_fail++; $display("FAIL mid_first_grant: got none expected A ack"); end
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    ev_q.delete();
    rv_q.delete();
    @(posedge clk);
    @(negedge clk);
    flags = {bus2.a_ack, bus2.b_ack, bus2.a_rvalid, bus2.b_rvalid, bus2.gb_we, bus2.gb_re};
    n_checks++;
    if (flags !== 6'b0 || bus2.gb_addr !== '0 || bus2.a_rdata !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got flags=%b addr=%h rdata=%h expected all 0",
                         flags, bus2.gb_addr, bus2.a_rdata);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (rv_q.size() != 0 || ev_q.size() != 0) begin
      n_fail++; $display("FAIL mid_abandoned: got %0d rvalid %0d events expected 0/0", rv_q.size(), ev_q.size());
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 24'h000060, 32'h6);
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 24'h000061, 32'h7);
    fork
      begin wait_ack(1'b0, 20, ac_a); a_req = 1'b0; end
      begin wait_ack(1'b1, 20, ac_b); b_req = 1'b0; end
    join
    repeat (3) @(negedge clk);
    n_checks++;
    if (ev_q.size() != 2 || ev_q[0].aa !== 1'b1 || ev_q[1].ba !== 1'b1) begin
      n_fail++; $display("FAIL mid_ptr_reset: got %0d events first_aa=%b expected A then B",
                         ev_q.size(), (ev_q.size() > 0) ? ev_q[0].aa : 1'b0);
    end
  endtask

  task automatic test_latency_sweep();
    int n1 = -1, n2 = -1, n15 = -1, r1 = -1, r2 = -1, r15 = -1;
    logic [DW-1:0] d1, d2, d15;
    logic [AW-1:0] ad;
    do_reset();
    ad = AW'($urandom);
    @(posedge clk); #1 set_req(1'b1, 1'b1, 1'b0, 1'b1, ad, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus2.b_ack === 1'b1) b_req = 1'b0;
      if (bus1.gb_re === 1'b1)  n1 = cyc;
      if (bus2.gb_re === 1'b1)  n2 = cyc;
      if (bus15.gb_re === 1'b1) n15 = cyc;
      if (bus1.b_rvalid === 1'b1)  begin r1 = cyc;  d1 = bus1.b_rdata;  end
      if (bus2.b_rvalid === 1'b1)  begin r2 = cyc;  d2 = bus2.b_rdata;  end
      if (bus15.b_rvalid === 1'b1) begin r15 = cyc; d15 = bus15.b_rdata; end
    end
    n_checks++;
    if (n1 < 0 || r1 - n1 != 2 || d1 !== rd_fn(ad)) begin
      n_fail++; $display("FAIL lat1: got delay=%0d d=%h expected 2 %h", r1 - n1, d1, rd_fn(ad));
    end
    n_checks++;
    if (n2 < 0 || r2 - n2 != 3 || d2 !== rd_fn(ad)) begin
      n_fail++; $display("FAIL lat2: got delay=%0d d=%h expected 3 %h", r2 - n2, d2, rd_fn(ad));
    end
    n_checks++;
    if (n15 < 0 || r15 - n15 != 16 || d15 !== rd_fn(ad)) begin
      n_fail++; $display("FAIL lat15: got delay=%0d d=%h expected 16 %h", r15 - n15, d15, rd_fn(ad));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_single_op(1'b1, 1'b1, 24'h000020, 4'b1010);
    test_single_op(1'b0, 1'b0, 24'h000088, 4'b0010);
    test_reset_mid();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
